// File: rtl/ace_dispatch_credit_pkg.sv
// ace_dispatch_pkg: shared depths, slot class encoding, FSM states and credit width helper
package ace_dispatch_pkg;
  localparam int DISP_WIDTH     = 4;
  localparam int IQ_INT_DEPTH_D = 16;
  localparam int IQ_MEM_DEPTH_D = 16;
  localparam int IQ_CPX_DEPTH_D = 8;
  localparam int AL_DEPTH_D     = 64;
  localparam int LSQ_DEPTH_D    = 32;
  localparam int FLUSH_HOLD_D   = 2;
  typedef enum logic [1:0] {NONE, IQ_INT, IQ_MEM, IQ_CPX} slot_class_e;
  typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_e;
  function automatic int cred_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic slot_class_e slot_class(input logic mem, input logic br, input logic simple, input logic cpx);
    return mem ? IQ_MEM : cpx ? IQ_CPX : (br | simple) ? IQ_INT : NONE;
  endfunction
endpackage

// File: rtl/ace_dispatch_credit_if.sv
// ace_dispatch_credit_if: dispatch packet, release and credit/grant bundle
interface ace_dispatch_credit_if
  import ace_dispatch_pkg::*;
#(
  parameter int IQ_INT_DEPTH = IQ_INT_DEPTH_D,
  parameter int IQ_MEM_DEPTH = IQ_MEM_DEPTH_D,
  parameter int IQ_CPX_DEPTH = IQ_CPX_DEPTH_D,
  parameter int AL_DEPTH     = AL_DEPTH_D,
  parameter int LSQ_DEPTH    = LSQ_DEPTH_D
);
  logic stall_i, flush_i;
  logic [3:0] slot_valid_i, slot_memory_i, slot_branch_i, slot_simple_i, slot_complx_i;
  logic [2:0] iq_int_rel_i, iq_mem_rel_i, iq_cpx_rel_i, al_rel_i, lsq_rel_i;
  logic [3:0] dispatch_ok_o;
  logic [2:0] dispatch_cnt_o;
  logic stall_o, hold_o;
  logic [cred_w(IQ_INT_DEPTH)-1:0] iq_int_cred_o;
  logic [cred_w(IQ_MEM_DEPTH)-1:0] iq_mem_cred_o;
  logic [cred_w(IQ_CPX_DEPTH)-1:0] iq_cpx_cred_o;
  logic [cred_w(AL_DEPTH)-1:0] al_cred_o;
  logic [cred_w(LSQ_DEPTH)-1:0] lsq_cred_o;
  modport master (
    output stall_i, flush_i, slot_valid_i, slot_memory_i, slot_branch_i, slot_simple_i, slot_complx_i,
    output iq_int_rel_i, iq_mem_rel_i, iq_cpx_rel_i, al_rel_i, lsq_rel_i,
    input dispatch_ok_o, dispatch_cnt_o, stall_o, hold_o,
    input iq_int_cred_o, iq_mem_cred_o, iq_cpx_cred_o, al_cred_o, lsq_cred_o
  );
  modport slave (
    input stall_i, flush_i, slot_valid_i, slot_memory_i, slot_branch_i, slot_simple_i, slot_complx_i,
    input iq_int_rel_i, iq_mem_rel_i, iq_cpx_rel_i, al_rel_i, lsq_rel_i,
    output dispatch_ok_o, dispatch_cnt_o, stall_o, hold_o,
    output iq_int_cred_o, iq_mem_cred_o, iq_cpx_cred_o, al_cred_o, lsq_cred_o
  );
endinterface

// File: rtl/ace_dispatch_credit_counter.sv
// ace_credit_counter: free-entry counter with consume, release, flush reload and saturation at DEPTH
module ace_credit_counter
  import ace_dispatch_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int W = cred_w(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reload,
  input  logic [2:0]   consume,
  input  logic [2:0]   rel,
  output logic [W-1:0] cred
);
  logic [W:0] sum, nxt;
  always_comb begin
    sum = {1'b0, cred} + (W+1)'(rel);
    nxt = sum < (W+1)'(consume) ? '0 : sum - (W+1)'(consume);
  end
  always_ff @(posedge clock)
    cred <= (reset || reload) ? W'(DEPTH) : nxt > (W+1)'(DEPTH) ? W'(DEPTH) : nxt[W-1:0];
  over_release: assert property (@(posedge clock) disable iff (reset || reload) nxt <= (W+1)'(DEPTH));
endmodule

// File: rtl/ace_dispatch_credit.sv
// ace_dispatch_credit: grants an in-order prefix of the 4-wide dispatch packet against five credit pools
module ace_dispatch_credit
  import ace_dispatch_pkg::*;
#(
  parameter int WIDTH        = DISP_WIDTH,
  parameter int IQ_INT_DEPTH = IQ_INT_DEPTH_D,
  parameter int IQ_MEM_DEPTH = IQ_MEM_DEPTH_D,
  parameter int IQ_CPX_DEPTH = IQ_CPX_DEPTH_D,
  parameter int AL_DEPTH     = AL_DEPTH_D,
  parameter int LSQ_DEPTH    = LSQ_DEPTH_D,
  parameter int FLUSH_HOLD   = FLUSH_HOLD_D
) (
  input logic clock,
  input logic reset,
  ace_dispatch_credit_if.slave d
);
  localparam int HW = $clog2(FLUSH_HOLD) + 1;
  state_e state;
  logic [HW-1:0] hold_cnt;
  logic [3:0] ok, illegal;
  logic [2:0] n_int, n_mem, n_cpx, n_al, t_int, t_mem, t_cpx, t_al;
  logic go, prev, fit;
  slot_class_e c;
  always_comb begin
    go = !reset && state == RUN && !d.stall_i && !d.flush_i;
    prev = go;
    ok = '0;
    illegal = '0;
    c = NONE;
    {n_int, n_mem, n_cpx, n_al} = '0;
    {t_int, t_mem, t_cpx, t_al} = '0;
    fit = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      c = slot_class(d.slot_memory_i[k], d.slot_branch_i[k], d.slot_simple_i[k], d.slot_complx_i[k]);
      illegal[k] = d.slot_valid_i[k] && !$onehot0({d.slot_memory_i[k], d.slot_branch_i[k], d.slot_simple_i[k], d.slot_complx_i[k]});
      t_int = n_int + 3'(c == IQ_INT);
      t_mem = n_mem + 3'(c == IQ_MEM);
      t_cpx = n_cpx + 3'(c == IQ_CPX);
      t_al  = n_al + 3'd1;
      // memory ops draw on both the memory IQ and the LSQ
      fit = int'(t_int) <= int'(d.iq_int_cred_o) && int'(t_mem) <= int'(d.iq_mem_cred_o) &&
            int'(t_mem) <= int'(d.lsq_cred_o) && int'(t_cpx) <= int'(d.iq_cpx_cred_o) &&
            int'(t_al) <= int'(d.al_cred_o);
      prev = prev && d.slot_valid_i[k] && fit;
      ok[k] = prev;
      if (prev) {n_int, n_mem, n_cpx, n_al} = {t_int, t_mem, t_cpx, t_al};
    end
  end
  assign d.dispatch_ok_o  = ok;
  assign d.dispatch_cnt_o = n_al;
  assign d.stall_o        = !reset && |(d.slot_valid_i & ~ok);
  assign d.hold_o         = !reset && state == HOLD;
  always_ff @(posedge clock)
    if (reset) begin
      state <= RUN;
      hold_cnt <= '0;
    end else if (d.flush_i) begin
      state <= HOLD;
      hold_cnt <= HW'(FLUSH_HOLD - 1);
    end else if (state == HOLD) begin
      state <= hold_cnt == '0 ? RUN : HOLD;
      hold_cnt <= hold_cnt == '0 ? '0 : hold_cnt - 1'b1;
    end
  illegal_class: assert property (@(posedge clock) disable iff (reset) illegal == '0);
  ace_credit_counter #(.DEPTH(IQ_INT_DEPTH)) u_iq_int (.clock, .reset, .reload(d.flush_i), .consume(n_int), .rel(d.iq_int_rel_i), .cred(d.iq_int_cred_o));
  ace_credit_counter #(.DEPTH(IQ_MEM_DEPTH)) u_iq_mem (.clock, .reset, .reload(d.flush_i), .consume(n_mem), .rel(d.iq_mem_rel_i), .cred(d.iq_mem_cred_o));
  ace_credit_counter #(.DEPTH(IQ_CPX_DEPTH)) u_iq_cpx (.clock, .reset, .reload(d.flush_i), .consume(n_cpx), .rel(d.iq_cpx_rel_i), .cred(d.iq_cpx_cred_o));
  ace_credit_counter #(.DEPTH(AL_DEPTH)) u_al (.clock, .reset, .reload(d.flush_i), .consume(n_al), .rel(d.al_rel_i), .cred(d.al_cred_o));
  ace_credit_counter #(.DEPTH(LSQ_DEPTH)) u_lsq (.clock, .reset, .reload(d.flush_i), .consume(n_mem), .rel(d.lsq_rel_i), .cred(d.lsq_cred_o));
endmodule

// File: tb/tb_ace_dispatch_credit.sv
// tb_ace_dispatch_credit: random and directed stimulus checked every cycle against a credit-pool model
module tb_ace_dispatch_credit;
  localparam int HOLD_CYC = 2;
  int dep [5] = '{16, 16, 8, 64, 32};
  int m_cred [5] = '{16, 16, 8, 64, 32};
  int m_hold = 0;
  int checks = 0, fails = 0;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  ace_dispatch_credit_if d ();
  ace_dispatch_credit dut (.clock(clock), .reset(reset), .d(d));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // pools: 0 int IQ, 1 mem IQ, 2 cpx IQ, 3 active list, 4 LSQ
  function automatic void model_grant(output int n, output int used [5]);
    int need [5];
    n = 0;
    used = '{0, 0, 0, 0, 0};
    if (reset || d.flush_i || d.stall_i || m_hold > 0) return;
    need = '{0, 0, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      if (!d.slot_valid_i[k]) break;
      need[3]++;
      if (d.slot_memory_i[k]) begin need[1]++; need[4]++; end
      else if (d.slot_complx_i[k]) need[2]++;
      else if (d.slot_simple_i[k] || d.slot_branch_i[k]) need[0]++;
      if (need[0] > m_cred[0] || need[1] > m_cred[1] || need[2] > m_cred[2] ||
          need[3] > m_cred[3] || need[4] > m_cred[4]) break;
      n++;
      used = need;
    end
  endfunction

  always @(negedge clock) begin
    int n;
    int used [5];
    logic [3:0] eok;
    model_grant(n, used);
    eok = 4'((1 << n) - 1);
    chk("dispatch_ok", int'(d.dispatch_ok_o), int'(eok));
    chk("dispatch_cnt", int'(d.dispatch_cnt_o), n);
    chk("stall_o", int'(d.stall_o), int'(!reset && (d.slot_valid_i & ~eok) != 4'h0));
    chk("hold_o", int'(d.hold_o), int'(!reset && m_hold > 0));
    chk("iq_int_cred", int'(d.iq_int_cred_o), m_cred[0]);
    chk("iq_mem_cred", int'(d.iq_mem_cred_o), m_cred[1]);
    chk("iq_cpx_cred", int'(d.iq_cpx_cred_o), m_cred[2]);
    chk("al_cred", int'(d.al_cred_o), m_cred[3]);
    chk("lsq_cred", int'(d.lsq_cred_o), m_cred[4]);
  end

  always @(posedge clock) begin
    int n;
    int used [5];
    int rel [5];
    model_grant(n, used);
    rel = '{int'(d.iq_int_rel_i), int'(d.iq_mem_rel_i), int'(d.iq_cpx_rel_i), int'(d.al_rel_i), int'(d.lsq_rel_i)};
    if (reset || d.flush_i) begin
      m_cred = dep;
      m_hold = reset ? 0 : HOLD_CYC;
    end else begin
      if (m_hold > 0) m_hold--;
      for (int i = 0; i < 5; i++) begin
        int x;
        x = m_cred[i] - used[i] + rel[i];
        m_cred[i] = x > dep[i] ? dep[i] : x;
      end
    end
  end

  // class codes: 0 nop, 1 simple, 2 branch, 3 memory, 4 complex
  task automatic slots(input logic [3:0] v, input int c [4]);
    d.slot_valid_i = v;
    for (int k = 0; k < 4; k++) begin
      d.slot_simple_i[k] = c[k] == 1;
      d.slot_branch_i[k] = c[k] == 2;
      d.slot_memory_i[k] = c[k] == 3;
      d.slot_complx_i[k] = c[k] == 4;
    end
  endtask
  task automatic rels(input int a, input int b, input int c, input int e, input int f);
    d.iq_int_rel_i = 3'(a);
    d.iq_mem_rel_i = 3'(b);
    d.iq_cpx_rel_i = 3'(c);
    d.al_rel_i = 3'(e);
    d.lsq_rel_i = 3'(f);
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    d.stall_i = 1'b0;
    d.flush_i = 1'b0;
    slots(4'hf, '{1, 1, 1, 1});
    rels(0, 0, 0, 0, 0);
    tick;
    tick;
    #1;
    chk("rst_ok", int'(d.dispatch_ok_o), 0);
    chk("rst_stall", int'(d.stall_o), 0);
    chk("rst_hold", int'(d.hold_o), 0);
    chk("rst_al", int'(d.al_cred_o), 64);
    chk("rst_cpx", int'(d.iq_cpx_cred_o), 8);
    reset = 1'b0;
    #1;
    chk("simple4_ok", int'(d.dispatch_ok_o), 4'b1111);
    chk("simple4_cnt", int'(d.dispatch_cnt_o), 4);
    tick;
    chk("simple4_int", int'(d.iq_int_cred_o), 12);
    chk("simple4_al", int'(d.al_cred_o), 60);
    slots(4'hf, '{4, 4, 4, 4});
    tick;
    slots(4'b0111, '{4, 4, 4, 0});
    #1;
    chk("cpx3_ok", int'(d.dispatch_ok_o), 4'b0111);
    tick;
    chk("cpx_cred1", int'(d.iq_cpx_cred_o), 1);
    slots(4'hf, '{4, 1, 4, 1});
    #1;
    chk("cpx_mix_ok", int'(d.dispatch_ok_o), 4'b0011);
    chk("cpx_mix_stall", int'(d.stall_o), 1);
    tick;
    chk("cpx_cred0", int'(d.iq_cpx_cred_o), 0);
    slots(4'hf, '{3, 3, 3, 3});
    for (int i = 0; i < 6; i++) begin
      tick;
      rels(0, 4, 0, 4, 0);
    end
    tick;
    slots(4'b0011, '{3, 3, 3, 3});
    tick;
    chk("lsq_cred2", int'(d.lsq_cred_o), 2);
    slots(4'hf, '{3, 3, 3, 3});
    rels(0, 0, 0, 0, 2);
    #1;
    chk("lsq_rel_ok", int'(d.dispatch_ok_o), 4'b0011);
    chk("lsq_rel_stall", int'(d.stall_o), 1);
    tick;
    chk("lsq_after", int'(d.lsq_cred_o), 2);
    slots(4'b0011, '{3, 3, 3, 3});
    rels(0, 0, 0, 0, 0);
    #1;
    chk("lsq_rest_ok", int'(d.dispatch_ok_o), 4'b0011);
    chk("lsq_rest_stall", int'(d.stall_o), 0);
    tick;
    slots(4'b1101, '{1, 1, 1, 1});
    #1;
    chk("gap_ok", int'(d.dispatch_ok_o), 4'b0001);
    chk("gap_stall", int'(d.stall_o), 1);
    tick;
    slots(4'hf, '{1, 1, 1, 1});
    d.flush_i = 1'b1;
    #1;
    chk("flush_ok", int'(d.dispatch_ok_o), 0);
    tick;
    d.flush_i = 1'b0;
    #1;
    chk("hold1", int'(d.hold_o), 1);
    chk("hold1_ok", int'(d.dispatch_ok_o), 0);
    chk("hold1_lsq", int'(d.lsq_cred_o), 32);
    chk("hold1_int", int'(d.iq_int_cred_o), 16);
    tick;
    chk("hold2", int'(d.hold_o), 1);
    chk("hold2_ok", int'(d.dispatch_ok_o), 0);
    tick;
    chk("resume_hold", int'(d.hold_o), 0);
    chk("resume_ok", int'(d.dispatch_ok_o), 4'b1111);
    tick;
    d.stall_i = 1'b1;
    rels(2, 0, 0, 0, 0);
    #1;
    chk("stall_ok", int'(d.dispatch_ok_o), 0);
    chk("stall_stall", int'(d.stall_o), 1);
    tick;
    rels(0, 0, 0, 0, 0);
    chk("stall_int", int'(d.iq_int_cred_o), 14);
    chk("stall_al", int'(d.al_cred_o), 60);
    d.stall_i = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int c [4];
      int r [5];
      tick;
      for (int k = 0; k < 4; k++) c[k] = int'($urandom_range(0, 4));
      slots(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf, c);
      for (int i = 0; i < 5; i++) begin
        int room;
        room = dep[i] - m_cred[i];
        r[i] = int'($urandom_range(0, room > 4 ? 4 : room));
      end
      rels(r[0], r[1], r[2], r[3], r[4]);
      d.stall_i = $urandom_range(0, 7) == 0;
      d.flush_i = $urandom_range(0, 39) == 0;
    end
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
